// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the fifo write port between N_REQ producers.
// The current owner may issue up to BURST back-to-back writes before it must yield.
module fifo_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int BURST  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  input  logic                      fifo_full,
  output logic                      fifo_write_en,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BURST + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W:0]   N_REQ_W  = (IDX_W + 1)'(N_REQ);
  localparam logic [CNT_W-1:0] BURST_C  = CNT_W'(BURST);

  // Handshake: requester i holds req[i] and its data slice steady; the word is
  // consumed on every rising edge where gnt[i]=1. There is no other acknowledgement.

  logic [CNT_W-1:0] burst_cnt;
  logic [IDX_W-1:0] rr_ptr;

  logic             keep_owner;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W:0]   scan;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] x);
    return (x == LAST_IDX) ? '0 : x + 1'b1;
  endfunction

  assign keep_owner = busy && req[owner] && (burst_cnt < BURST_C);

  // First active requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (scan >= N_REQ_W) scan = scan - N_REQ_W;
      if (!pick_found && req[scan[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan[IDX_W-1:0];
      end
    end
  end

  // Reset and a full fifo both suppress every grant before the normal rules apply.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (reset && !fifo_full) begin
      if (keep_owner) begin
        grant_valid = 1'b1;
        grant_idx   = owner;
      end else if (pick_found) begin
        grant_valid = 1'b1;
        grant_idx   = pick_idx;
      end
    end
  end

  always_comb begin
    gnt          = '0;
    fifo_data_in = '0;
    if (grant_valid) begin
      gnt[grant_idx] = 1'b1;
      fifo_data_in   = req_data[int'(grant_idx)*DATA_W +: DATA_W];
    end
  end

  assign fifo_write_en = grant_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner     <= '0;
      burst_cnt <= '0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
    end else if (!fifo_full) begin
      if (keep_owner) begin
        burst_cnt <= burst_cnt + 1'b1;
      end else if (pick_found) begin
        owner     <= pick_idx;
        burst_cnt <= CNT_W'(1);
        busy      <= 1'b1;
        rr_ptr    <= next_idx(pick_idx);
      end else begin
        busy      <= 1'b0;
        burst_cnt <= '0;
        if (busy) rr_ptr <= next_idx(owner);
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: reset, single requester, round-robin,
// full stall, early drop and reset in the middle of a burst.
module tb_fifo_write_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 32;
  localparam int BURST  = 4;

  logic                      clk;
  logic                      reset;
  logic [N_REQ-1:0]          req;
  logic [N_REQ*DATA_W-1:0]   req_data;
  logic [N_REQ-1:0]          gnt;
  logic                      fifo_full;
  logic                      fifo_write_en;
  logic [DATA_W-1:0]         fifo_data_in;
  logic [1:0]                owner;
  logic                      busy;

  int errors = 0;
  int checks = 0;

  fifo_write_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .BURST(BURST)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_write_en(fifo_write_en),
    .fifo_data_in(fifo_data_in), .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, check the combinational write port, then step past the edge.
  task automatic cyc(input string tag, input logic [3:0] r, input logic full,
                     input logic [3:0] exp_gnt, input logic [31:0] exp_data);
    req       = r;
    fifo_full = full;
    #1;
    chk({tag, ".gnt"},  32'(gnt), 32'(exp_gnt));
    chk({tag, ".we"},   32'(fifo_write_en), 32'(|exp_gnt));
    chk({tag, ".data"}, fifo_data_in, exp_data);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp_owner, input logic exp_busy);
    chk({tag, ".owner"}, 32'(owner), 32'(exp_owner));
    chk({tag, ".busy"},  32'(busy),  32'(exp_busy));
  endtask

  initial begin
    reset     = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    req_data  = '0;
    for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = 32'(i + 1);

    // 1. reset held with all requests active
    cyc("rst0", 4'b1111, 1'b0, 4'b0000, 32'd0);
    cyc("rst1", 4'b1111, 1'b0, 4'b0000, 32'd0);
    chk_state("rst", 2'd0, 1'b0);

    // 2. single requester streams through a burst boundary without a gap
    reset = 1'b1;
    req_data[2*DATA_W +: DATA_W] = 32'd50;
    for (int c = 0; c < 6; c++) cyc($sformatf("single%0d", c), 4'b0100, 1'b0, 4'b0100, 32'd50);
    chk_state("single", 2'd2, 1'b1);
    cyc("idle", 4'b0000, 1'b0, 4'b0000, 32'd0);
    chk_state("idle", 2'd2, 1'b0);

    // restart from rr_ptr=0 for the round-robin pattern
    reset = 1'b0;
    cyc("rst2", 4'b0000, 1'b0, 4'b0000, 32'd0);
    chk_state("rst2", 2'd0, 1'b0);
    reset = 1'b1;
    req_data[2*DATA_W +: DATA_W] = 32'd3;

    // 3. all request: four words each, rotating 0,1,2,3, then back to 0
    for (int o = 0; o < 4; o++)
      for (int c = 0; c < BURST; c++)
        cyc($sformatf("rr_o%0d_c%0d", o, c), 4'b1111, 1'b0, 4'(1 << o), 32'(o + 1));
    chk_state("rr_wrap_pre", 2'd3, 1'b1);
    cyc("rr_wrap", 4'b1111, 1'b0, 4'b0001, 32'd1);
    chk_state("rr_wrap", 2'd0, 1'b1);

    // 4. owner 0 at two writes, fifo full for three cycles, then finishes its burst
    cyc("pre_full", 4'b0011, 1'b0, 4'b0001, 32'd1);
    for (int c = 0; c < 3; c++) cyc($sformatf("full%0d", c), 4'b0011, 1'b1, 4'b0000, 32'd0);
    chk_state("full", 2'd0, 1'b1);
    cyc("post_full0", 4'b0011, 1'b0, 4'b0001, 32'd1);
    cyc("post_full1", 4'b0011, 1'b0, 4'b0001, 32'd1);
    cyc("yield1",     4'b0011, 1'b0, 4'b0010, 32'd2);
    chk_state("yield1", 2'd1, 1'b1);

    // 5. owner 1 drops after two writes; 3 takes over the same cycle, rr_ptr moves to 0
    cyc("own1_w2", 4'b0011, 1'b0, 4'b0010, 32'd2);
    cyc("drop1",   4'b1000, 1'b0, 4'b1000, 32'd4);
    chk_state("drop1", 2'd3, 1'b1);
    cyc("after3",  4'b0011, 1'b0, 4'b0001, 32'd1);
    chk_state("after3", 2'd0, 1'b1);

    // 6. reset in the middle of owner 2's burst
    cyc("own2_a", 4'b0100, 1'b0, 4'b0100, 32'd3);
    cyc("own2_b", 4'b0100, 1'b0, 4'b0100, 32'd3);
    reset = 1'b0;
    cyc("rst_mid", 4'b1111, 1'b0, 4'b0000, 32'd0);
    chk_state("rst_mid", 2'd0, 1'b0);
    reset = 1'b1;
    cyc("restart", 4'b1111, 1'b0, 4'b0001, 32'd1);
    chk_state("restart", 2'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
